mtrx_loader: RTL and testbench
==============================

// Module: mtrx_loader
// PURPOSE
//   Upstream feeder for the matrix multiplier. Accepts matrix elements one per beat over a
//   valid/ready byte stream and assembles them into packed row-major matrices.
//   Collects operand A, then either operand B (matrix-matrix) or a scalar (matrix-scalar).
//   Presents the operands, scalar and mode, held stable, until the multiplier side acknowledges.
// PARAMETERS
//   ELEM_W  8  element width in bits
//   DIM     5  matrix dimension (DIM x DIM); MAT_W = DIM*DIM*ELEM_W = 200 by default
// PORTS
//   clock      in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high; clears all state
//   start      in   1       begin a load; sampled in IDLE, or in HOLD together with out_ack
//   start_mode in   1       0 = matrix-matrix (load A then B), 1 = matrix-scalar (A then scalar)
//   in_valid   in   1       in_data carries an element
//   in_ready   out  1       loader accepts an element this cycle
//   in_data    in   ELEM_W  element value
//   a          out  MAT_W   operand A; element k = row*DIM+col is at a[k*ELEM_W +: ELEM_W]
//   b          out  MAT_W   operand B, same packing
//   scalar     out  ELEM_W  scalar operand
//   mode       out  1       mode latched at start; connects to the multiplier's mode input
//   out_valid  out  1       operands are complete and held stable
//   out_ack    in   1       consumer has taken the operands
//   busy       out  1       state is not IDLE
//   err        out  1       only when MTRX_LOADER_ERR_EN is defined
// BEHAVIOUR
//   Reset values: a=0, b=0, scalar=0, mode=0, out_valid=0, in_ready=0, busy=0, err=0.
//   Reset clears everything immediately from any state, including mid-load.
//   States: IDLE -> LOAD_A -> (LOAD_B | LOAD_S) -> HOLD -> IDLE.
//   IDLE: start=1 latches mode<=start_mode, clears the element counter idx, and goes to LOAD_A.
//   Beat: a beat occurs when in_valid && in_ready.
//     - in_ready = 1 exactly in LOAD_A, LOAD_B and LOAD_S (a registered, state-decoded output).
//     - No combinational path from in_valid to in_ready.
//   LOAD_A: each beat writes in_data to a[idx] and sets idx <= idx+1.
//     - On the beat with idx=DIM*DIM-1, idx wraps to 0.
//     - Next state is LOAD_B if mode=0, LOAD_S if mode=1.
//   LOAD_B: same as LOAD_A, writing b. The last beat goes to HOLD.
//   LOAD_S: one beat writes scalar and goes to HOLD. In this mode b keeps its previous value.
//   Operands not reloaded keep their previous values: scalar in mode 0, b in mode 1.
//   No beat means no state change; in_valid may drop at any time without penalty.
//   HOLD: out_valid=1, and a, b, scalar and mode are held stable.
//     - out_ack=1: out_valid drops on the next edge and the state goes to IDLE.
//     - out_ack=1 with start=1 in the same cycle: go straight to LOAD_A with the new start_mode.
//       This is back-to-back operation; out_valid drops.
//   out_ack outside HOLD is ignored.
//   Latency: the last element beat at edge N gives out_valid=1 after edge N.
//   Minimum load time is 50 beats in mode 0 and 26 beats in mode 1.
//   Element counter width is $clog2(DIM*DIM). Values are never checked against DIM*DIM.
//   Elements are stored verbatim: no arithmetic, no truncation.
// CONFIGURATION
//   MTRX_LOADER_ERR_EN defined:
//     - start=1 while in LOAD_A, LOAD_B or LOAD_S aborts the load and returns to IDLE.
//     - The partially written registers keep whatever they hold.
//     - err is set to 1 and is sticky; it clears on the next accepted start, or on reset.
//     - A start that is also accepted in the same cycle is not possible, because abort goes to IDLE.
//   MTRX_LOADER_ERR_EN undefined:
//     - start while loading is ignored, and the load continues.
//     - The err port does not exist.
// STRUCTURE
//   Shared package: the state encoding (IDLE, LOAD_A, LOAD_B, LOAD_S, HOLD).
//   Shared package: the mode constants MODE_MAT=0, MODE_SCL=1.
//   Shared package: the defaults ELEM_W=8, DIM=5, and MAT_W, so the multiplier uses the same values.
//   Single flat module, no sub-module. Writes use indexed part-select on idx.
// TESTING
//   1. Reset held, then released with no stimulus -> all outputs 0, state IDLE, in_ready=0.
//   2. start with mode 0; stream A = 1,2,1,2,...(25 values), then B = all 1, in_valid held high
//      -> out_valid one cycle after beat 50; a[7:0]=1, a[15:8]=2, b=all 1, mode=0.
//      Driving the multiplier from these outputs gives rows 7,8,7,8,7.
//   3. start with mode 1; stream A as in case 2, then 8'd2
//      -> out_valid after beat 26, scalar=2, b unchanged from case 2, mode=1.
//   4. Random in_valid gaps in mode 0 -> same result as case 2. in_ready never 1 in IDLE or HOLD.
//   5. In HOLD, hold out_ack=0 for 10 cycles -> outputs stable throughout.
//      Then out_ack=1 with start=1, start_mode=1 -> next state LOAD_A, out_valid=0, mode=1.
//   6. Assert reset after beat 12 of A -> all outputs 0 at once.
//      With MTRX_LOADER_ERR_EN: start at beat 12 -> IDLE, err=1; the next start -> err=0.

Source files
------------

// File: rtl/mtrx_loader_pkg.sv
// Shared definitions for the matrix loader and the multiplier it feeds: element/matrix sizing,
// mode constants and the loader state encoding.
package mtrx_loader_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned DIM    = 5;
  localparam int unsigned MAT_W  = DIM * DIM * ELEM_W;

  localparam logic MODE_MAT = 1'b0;
  localparam logic MODE_SCL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StLoadS,
    StHold
  } state_e;

endpackage

// File: rtl/mtrx_loader.sv
// Assembles a streamed element sequence into packed row-major operands for the multiplier.
// Optional MTRX_LOADER_ERR_EN: start while loading aborts the load and sets a sticky err flag.
module mtrx_loader #(
  parameter int unsigned ELEM_W = mtrx_loader_pkg::ELEM_W,
  parameter int unsigned DIM    = mtrx_loader_pkg::DIM,
  localparam int unsigned MAT_W = DIM * DIM * ELEM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              start_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic [MAT_W-1:0]  a,
  output logic [MAT_W-1:0]  b,
  output logic [ELEM_W-1:0] scalar,
  output logic              mode,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy
`ifdef MTRX_LOADER_ERR_EN
  ,
  output logic              err
`endif
);

  import mtrx_loader_pkg::*;

  localparam int unsigned IDX_W = $clog2(DIM * DIM);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIM * DIM - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MAT_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ELEM_W-1:0]  scalar_q, scalar_d;
  logic               mode_q, mode_d;
  logic               in_ready_q, out_valid_q;
  logic               beat;
`ifdef MTRX_LOADER_ERR_EN
  logic               err_q, err_d;
`endif

  // in_ready is a flop of the next state, so it never depends on in_valid.
  assign beat = in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    mode_d   = mode_q;
`ifdef MTRX_LOADER_ERR_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = start_mode;
          idx_d   = '0;
          state_d = StLoadA;
`ifdef MTRX_LOADER_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      StLoadA, StLoadB: begin
`ifdef MTRX_LOADER_ERR_EN
        if (start) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else
`endif
        if (beat) begin
          if (state_q == StLoadA) a_d[idx_q*ELEM_W +: ELEM_W] = in_data;
          else                    b_d[idx_q*ELEM_W +: ELEM_W] = in_data;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (state_q == StLoadB)       state_d = StHold;
            else if (mode_q == MODE_SCL) state_d = StLoadS;
            else                         state_d = StLoadB;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StLoadS: begin
`ifdef MTRX_LOADER_ERR_EN
        if (start) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else
`endif
        if (beat) begin
          scalar_d = in_data;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (out_ack) begin
          if (start) begin
            mode_d  = start_mode;
            idx_d   = '0;
            state_d = StLoadA;
`ifdef MTRX_LOADER_ERR_EN
            err_d   = 1'b0;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      scalar_q    <= '0;
      mode_q      <= MODE_MAT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MTRX_LOADER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      scalar_q    <= scalar_d;
      mode_q      <= mode_d;
      in_ready_q  <= (state_d == StLoadA) || (state_d == StLoadB) || (state_d == StLoadS);
      out_valid_q <= (state_d == StHold);
`ifdef MTRX_LOADER_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign scalar    = scalar_q;
  assign mode      = mode_q;
  assign busy      = (state_q != StIdle);
`ifdef MTRX_LOADER_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_mtrx_loader.sv
// Randomised self-checking bench for mtrx_loader against an array-based operand model.
module tb_mtrx_loader;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N      = DIM * DIM;
  localparam int MAT_W  = N * ELEM_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              start_mode = 1'b0;
  logic              in_valid = 1'b0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              out_ack = 1'b0;
  logic              in_ready, mode, out_valid, busy;
  logic [MAT_W-1:0]  a, b;
  logic [ELEM_W-1:0] scalar;
`ifdef MTRX_LOADER_ERR_EN
  logic              err;
`endif

  mtrx_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_mode (start_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .a          (a),
    .b          (b),
    .scalar     (scalar),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .busy       (busy)
`ifdef MTRX_LOADER_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: operands as plain element arrays.
  logic [ELEM_W-1:0] m_a [N];
  logic [ELEM_W-1:0] m_b [N];
  logic [ELEM_W-1:0] m_s;
  logic              m_mode;

  function automatic logic [MAT_W-1:0] pack_a();
    logic [MAT_W-1:0] v;
    for (int k = 0; k < N; k++) v[k*ELEM_W +: ELEM_W] = m_a[k];
    return v;
  endfunction

  function automatic logic [MAT_W-1:0] pack_b();
    logic [MAT_W-1:0] v;
    for (int k = 0; k < N; k++) v[k*ELEM_W +: ELEM_W] = m_b[k];
    return v;
  endfunction

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic send_beat(input logic [ELEM_W-1:0] v, input int max_gap, output bit ok);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // sel: 0 = A, 1 = B, 2 = scalar. pattern 1: A = 1,2,1,2..., B = all 1. Returns timeout count.
  task automatic load_elems(input int sel, input int first, input int count, input bit pattern,
                            input int max_gap, output int timeouts);
    logic [ELEM_W-1:0] v;
    bit ok;
    timeouts = 0;
    for (int k = first; k < first + count; k++) begin
      if (pattern) v = (sel == 0) ? ((k % 2 == 0) ? 8'd1 : 8'd2) : (sel == 1 ? 8'd1 : 8'd2);
      else         v = ELEM_W'($urandom);
      send_beat(v, max_gap, ok);
      if (!ok) timeouts++;
      else if (sel == 0) m_a[k] = v;
      else if (sel == 1) m_b[k] = v;
      else m_s = v;
    end
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    start_mode = m;
    @(posedge clock);
    #1;
    start = 1'b0;
    m_mode = m;
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    @(posedge clock);
    #1;
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      m_a[k] = '0;
      m_b[k] = '0;
    end
    m_s = '0;
    m_mode = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({a, b, scalar, mode, out_valid, in_ready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: outputs not all zero (busy=%b in_ready=%b out_valid=%b)",
               busy, in_ready, out_valid);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({a, b, scalar, mode, out_valid, in_ready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_released: outputs not all zero (busy=%b in_ready=%b)", busy, in_ready);
    end
`ifdef MTRX_LOADER_ERR_EN
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_mat_mat();
    int to0, to1, to2;
    int rows [DIM];
    int exp_rows [DIM];
    do_start(1'b0);
    load_elems(0, 0, N, 1'b1, 0, to0);
    load_elems(1, 0, N - 1, 1'b1, 0, to1);
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mm_before_last: out_valid=%b busy=%b want 0/1", out_valid, busy);
    end
    @(posedge clock);
    #1;
    load_elems(1, N - 1, 1, 1'b1, 0, to2);
    @(negedge clock);
    vectors++;
    if (to0 + to1 + to2 != 0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mm_done: timeouts=%0d out_valid=%b in_ready=%b want 0/1/0",
               to0 + to1 + to2, out_valid, in_ready);
    end
    vectors++;
    if (a !== pack_a() || b !== pack_b() || mode !== 1'b0 || scalar !== m_s) begin
      miscompares++;
      $display("FAIL mm_operands: a=%h b=%h mode=%b scalar=%h want a=%h b=%h mode=0 scalar=%h",
               a, b, mode, scalar, pack_a(), pack_b(), m_s);
    end
    // Row sums of A*B with B all ones; column 0 of the product.
    for (int r = 0; r < DIM; r++) begin
      rows[r] = 0;
      for (int j = 0; j < DIM; j++)
        rows[r] += int'(a[(r*DIM+j)*ELEM_W +: ELEM_W]) * int'(b[(j*DIM)*ELEM_W +: ELEM_W]);
      exp_rows[r] = (r % 2 == 0) ? 7 : 8;
    end
    vectors++;
    if (rows != exp_rows) begin
      miscompares++;
      $display("FAIL mm_product_rows: got %0d %0d %0d %0d %0d want 7 8 7 8 7",
               rows[0], rows[1], rows[2], rows[3], rows[4]);
    end
    @(posedge clock);
    #1;
    do_ack();
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mm_ack: out_valid=%b busy=%b in_ready=%b want 0/0/0",
               out_valid, busy, in_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mat_scalar();
    int to0, to1;
    do_start(1'b1);
    load_elems(0, 0, N, 1'b1, 0, to0);
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ms_after_a: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clock);
    #1;
    load_elems(2, 0, 1, 1'b1, 0, to1);
    @(negedge clock);
    vectors++;
    if (to0 + to1 != 0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ms_done: timeouts=%0d out_valid=%b want 0/1", to0 + to1, out_valid);
    end
    vectors++;
    if (scalar !== 8'd2 || b !== pack_b() || a !== pack_a() || mode !== 1'b1) begin
      miscompares++;
      $display("FAIL ms_operands: scalar=%h mode=%b b=%h want scalar=02 mode=1 b=%h",
               scalar, mode, b, pack_b());
    end
    @(posedge clock);
    #1;
    do_ack();
  endtask

  task automatic test_random_gaps();
    int to0, to1;
    out_ack = 1'b1;  // ignored outside HOLD
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ack_ignored: in_ready=%b busy=%b out_valid=%b want 0/0/0",
                 in_ready, busy, out_valid);
      end
      @(posedge clock);
      #1;
    end
    out_ack = 1'b0;
    do_start(1'b0);
    load_elems(0, 0, N, 1'b0, 3, to0);
    load_elems(1, 0, N, 1'b0, 3, to1);
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (to0 + to1 != 0 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          a !== pack_a() || b !== pack_b() || scalar !== m_s || mode !== 1'b0) begin
        miscompares++;
        $display("FAIL gaps_hold: to=%0d out_valid=%b in_ready=%b a=%h b=%h want a=%h b=%h",
                 to0 + to1, out_valid, in_ready, a, b, pack_a(), pack_b());
      end
      @(posedge clock);
      #1;
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int to0, to1, to2;
    do_start(1'b0);
    load_elems(0, 0, N, 1'b0, 1, to0);
    load_elems(1, 0, N, 1'b0, 1, to1);
    for (int c = 0; c < 10; c++) begin
      start = 1'($urandom);  // start without out_ack must not leave HOLD
      start_mode = 1'($urandom);
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || a !== pack_a() ||
          b !== pack_b() || scalar !== m_s || mode !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: out_valid=%b in_ready=%b mode=%b a=%h b=%h", c,
                 out_valid, in_ready, mode, a, b);
      end
      @(posedge clock);
      #1;
    end
    out_ack = 1'b1;
    do_start(1'b1);
    out_ack = 1'b0;
    @(negedge clock);
    vectors++;
    if (to0 + to1 != 0 || out_valid !== 1'b0 || mode !== 1'b1 || in_ready !== 1'b1 ||
        busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: to=%0d out_valid=%b mode=%b in_ready=%b busy=%b want 0/1/1/1",
               to0 + to1, out_valid, mode, in_ready, busy);
    end
    @(posedge clock);
    #1;
    load_elems(0, 0, N, 1'b0, 2, to0);
    load_elems(2, 0, 1, 1'b0, 2, to2);
    @(negedge clock);
    vectors++;
    if (to0 + to2 != 0 || out_valid !== 1'b1 || a !== pack_a() || b !== pack_b() ||
        scalar !== m_s || mode !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_scalar: out_valid=%b scalar=%h mode=%b b=%h want scalar=%h b=%h",
               out_valid, scalar, mode, b, m_s, pack_b());
    end
    @(posedge clock);
    #1;
    do_ack();
  endtask

  task automatic test_reset_midload();
    int to0, to1;
    do_start(1'b1);
    load_elems(0, 0, 12, 1'b0, 1, to0);
    reset = 1'b1;
    #1;
    vectors++;
    if (to0 != 0 || {a, b, scalar, mode, out_valid, in_ready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_midload: to=%0d busy=%b in_ready=%b mode=%b a=%h", to0, busy,
               in_ready, mode, a);
    end
    for (int k = 0; k < N; k++) begin
      m_a[k] = '0;
      m_b[k] = '0;
    end
    m_s = '0;
    m_mode = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    do_start(1'b0);
    load_elems(0, 0, 12, 1'b0, 1, to0);
`ifdef MTRX_LOADER_ERR_EN
    start = 1'b1;
    start_mode = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (to0 != 0 || busy !== 1'b0 || err !== 1'b1 || in_ready !== 1'b0 ||
          a !== pack_a() || mode !== 1'b0) begin
        miscompares++;
        $display("FAIL err_abort: busy=%b err=%b in_ready=%b mode=%b a=%h want 0/1/0/0 a=%h",
                 busy, err, in_ready, mode, a, pack_a());
      end
      @(posedge clock);
      #1;
    end
    do_start(1'b0);
    @(negedge clock);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: err=%b busy=%b want 0/1", err, busy);
    end
    @(posedge clock);
    #1;
    load_elems(0, 0, N, 1'b0, 0, to0);
`else
    start = 1'b1;
    start_mode = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    vectors++;
    if (to0 != 0 || busy !== 1'b1 || in_ready !== 1'b1 || mode !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored: busy=%b in_ready=%b mode=%b want 1/1/0", busy, in_ready,
               mode);
    end
    @(posedge clock);
    #1;
    load_elems(0, 12, N - 12, 1'b0, 0, to0);
`endif
    load_elems(1, 0, N, 1'b0, 0, to1);
    @(negedge clock);
    vectors++;
    if (to0 + to1 != 0 || out_valid !== 1'b1 || a !== pack_a() || b !== pack_b() ||
        mode !== 1'b0) begin
      miscompares++;
      $display("FAIL after_midload: out_valid=%b mode=%b a=%h b=%h want a=%h b=%h", out_valid,
               mode, a, b, pack_a(), pack_b());
    end
    @(posedge clock);
    #1;
    do_ack();
  endtask

  initial begin
    test_reset();
    test_mat_mat();
    test_mat_scalar();
    test_random_gaps();
    test_back_to_back();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
